time_adjust_ctrl: RTL

Upstream stage of the digital clock's time-of-day counter. Conditions the raw hour and minute push-buttons, which are asynchronous and bouncy, and produces single-cycle increment pulses for the counter. Pulses auto-repeat while a button is held. Runs on the 100 MHz system clock with an internal millisecond tick. Pressing both buttons together suppresses all adjustment.

---
 rtl/time_adjust_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/time_adjust_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : time_adjust_ctrl                                          |
// | Purpose  : Conditions the raw hour/minute push-buttons (synchronise, |
// |            debounce on a divided tick) and emits single-cycle        |
// |            increment pulses with auto-repeat. Holding both buttons   |
// |            locks out all adjustment until they are released.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module time_adjust_ctrl #(
  parameter int TICK_DIV           = 100000,
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 200
) (
  input  logic clk_100M,
  input  logic rst_n,
  input  logic h,
  input  logic min,
  output logic hour_inc,
  output logic min_inc,
  output logic h_held,
  output logic min_held,
  output logic adj_active
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } adj_state_t;

  // Index 0 is the hour button, index 1 the minute button.
  logic [1:0]        raw;
  logic [1:0]        held_v;
  logic [1:0]        pulse_v;
  logic [1:0]        active_v;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              lock;

  assign raw  = {min, h};
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));
  // Both debounced buttons down at once suppresses all adjustment.
  assign lock = held_v[0] & held_v[1];

  // Free-running divider producing a one-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1;
      logic             sync2;
      logic [DB_W-1:0]  db_cnt;
      logic             held;
      logic             held_d;
      logic             wait_rel;
      logic             pulse;
      logic             fall_now;
      logic             leave;
      adj_state_t       state;
      logic [RPT_W-1:0] cnt;

      // The debounced level drops on this very edge: lets a release that
      // lands on a repeat tick win over the pulse that tick would cause.
      assign fall_now = tick & held & ~sync2 &
                        (db_cnt >= DB_W'(DEBOUNCE_TICKS - 1));
      assign leave    = ~held | fall_now;

      // Two-flop synchroniser for the asynchronous button input.
      always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
        end else begin
          sync1 <= raw[gi];
          sync2 <= sync1;
        end
      end

      // Debounce: flip the held level after DEBOUNCE_TICKS consecutive
      // ticks of disagreement; any agreeing tick restarts the count.
      always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt <= '0;
          held   <= 1'b0;
        end else if (tick) begin
          if (sync2 != held) begin
            if (db_cnt >= DB_W'(DEBOUNCE_TICKS - 1)) begin
              held   <= ~held;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end else begin
            db_cnt <= '0;
          end
        end
      end

      // Press / delay / auto-repeat sequencer with lock-out handling.
      always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
          state    <= S_IDLE;
          cnt      <= '0;
          pulse    <= 1'b0;
          held_d   <= 1'b0;
          wait_rel <= 1'b0;
        end else begin
          pulse  <= 1'b0;
          held_d <= held;
          // A button caught in a lock must be released before it counts.
          if (lock) begin
            wait_rel <= 1'b1;
          end else if (!held) begin
            wait_rel <= 1'b0;
          end

          if (lock) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            case (state)
              S_IDLE: begin
                if (held && !held_d && !wait_rel) begin
                  pulse <= 1'b1;
                  cnt   <= '0;
                  state <= S_DELAY;
                end
              end
              S_DELAY: begin
                if (leave) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                end else if (tick) begin
                  if (cnt >= RPT_W'(REPEAT_DELAY_TICKS - 1)) begin
                    pulse <= 1'b1;
                    cnt   <= '0;
                    state <= S_REPEAT;
                  end else begin
                    cnt <= cnt + RPT_W'(1);
                  end
                end
              end
              S_REPEAT: begin
                if (leave) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                end else if (tick) begin
                  if (cnt >= RPT_W'(REPEAT_RATE_TICKS - 1)) begin
                    pulse <= 1'b1;
                    cnt   <= '0;
                  end else begin
                    cnt <= cnt + RPT_W'(1);
                  end
                end
              end
              default: begin
                state <= S_IDLE;
                cnt   <= '0;
              end
            endcase
          end
        end
      end

      assign held_v[gi]   = held;
      assign pulse_v[gi]  = pulse;
      assign active_v[gi] = (state != S_IDLE);
    end
  endgenerate

  // Registered "some adjustment sequence is in progress" flag.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      adj_active <= 1'b0;
    end else begin
      adj_active <= active_v[0] | active_v[1];
    end
  end

  assign hour_inc = pulse_v[0];
  assign min_inc  = pulse_v[1];
  assign h_held   = held_v[0];
  assign min_held = held_v[1];

endmodule
`default_nettype wire
